dmem_arbiter: RTL and testbench

Single-port data-memory arbiter that shares the DataMem/Peripheral bus between the CPU MEM stage and a DMA requester, such as a UART receive-buffer writer. The CPU owns the bus by default. The DMA requester gets the bus for bounded bursts, either when the MEM stage is idle or when a starvation counter expires. While the DMA owns the bus, the arbiter asserts a pipeline stall so the CPU's in-flight memory access is held and replayed. It sits between the EX/MEM pipeline register outputs and the DataMem/Peripheral `rd/wr/addr/wdata/rdata` port.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Shared DataMem/Peripheral bus bundle: CPU MEM-stage port, DMA beat port and the memory side.
interface dmem_arbiter_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_last;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // arbiter side
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata, dma_last,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  // requesters and memory side
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_addr, dma_wdata, dma_last,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU owns the bus by default, DMA gets bounded bursts when the
// CPU is idle or after a starvation timeout; the CPU is stalled while the DMA owns the bus.
//
//   state | meaning
//   S_CPU | CPU drives memory; DMA waits (wait_cnt tracks starvation)
//   S_DMA | DMA beats drive memory; a busy CPU is stalled and replays later
module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic [15:0]   stall_cnt
);

  typedef enum logic {S_CPU, S_DMA} state_t;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic       cpu_busy;

  assign cpu_busy      = bus.cpu_rd | bus.cpu_wr;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;

  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    beat_nxt      = beat_cnt;
    bus.mem_rd    = bus.cpu_rd;
    bus.mem_wr    = bus.cpu_wr;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.dma_gnt   = 1'b0;
    bus.cpu_stall = 1'b0;
    case (state)
      S_CPU: begin
        if (bus.dma_req && (!cpu_busy || wait_cnt == WAIT_MAX)) begin
          state_nxt = S_DMA;
          wait_nxt  = 4'd0;
          beat_nxt  = 4'd0;
        end else if (!bus.dma_req) begin
          wait_nxt = 4'd0;
        end else if (wait_cnt != WAIT_MAX) begin
          wait_nxt = wait_cnt + 4'd1;
        end
      end
      S_DMA: begin
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.mem_wr    = bus.dma_req & bus.dma_wr;
        bus.mem_rd    = bus.dma_req & ~bus.dma_wr;
        bus.dma_gnt   = bus.dma_req;
        bus.cpu_stall = cpu_busy;
        wait_nxt      = 4'd0;
        if (!bus.dma_req) begin
          state_nxt = S_CPU;
        end else begin
          beat_nxt = beat_cnt + 4'd1;
          if (bus.dma_last || beat_cnt == BEAT_LAST) state_nxt = S_CPU;
        end
      end
      default: state_nxt = S_CPU;
    endcase
    // no memory strobe or grant may escape during reset, even mid-burst
    if (reset) begin
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.dma_gnt   = 1'b0;
      bus.cpu_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CPU;
      wait_cnt  <= 4'd0;
      beat_cnt  <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
      if (bus.cpu_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a CPU-read scoreboard.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] stall_cnt;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [31:0] pre_addr, pre_data;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr[9:2]] <= pre_data;
    else if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  typedef struct {
    logic        cpu_rd;
    logic [31:0] cpu_addr;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_last;
    logic        e_gnt;
    logic        e_stall;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t        vt [6];
  logic [31:0] cpu_q [$];
  int          checks = 0;
  int          errors = 0;
  int          wcount40 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // observe the bus mid-cycle; serviced CPU reads are checked against the scoreboard
  task automatic sample();
    @(negedge clk);
    if (!reset) begin
      if (bus.cpu_rd && !bus.cpu_stall) begin
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_read_unexpected addr=%h (no read expected this cycle)", bus.cpu_addr);
        end else begin
          chk("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
        end
      end
      if (bus.mem_wr && bus.mem_addr == 32'h40) wcount40++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_wr = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_last = 0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_we = 1; pre_addr = a; pre_data = d;
    advance();
    pre_we = 0;
  endtask

  task automatic scoreboard_drained(input string name);
    checks++;
    if (cpu_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending actual=%0d expected=0", name, cpu_q.size());
      cpu_q.delete();
    end
  endtask

  initial begin
    int          beat;
    int          ngnt;
    logic [15:0] s0;
    logic        eg;

    vt[0] = '{1'b0, 32'h0,  1'b1, 32'h10, 32'hA000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b0, 32'h0,  1'b1, 32'h10, 32'hA000_0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10};
    vt[2] = '{1'b0, 32'h0,  1'b1, 32'h14, 32'hA000_0014, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h14};
    vt[3] = '{1'b0, 32'h0,  1'b1, 32'h18, 32'hA000_0018, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h18};
    vt[4] = '{1'b1, 32'h10, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vt[5] = '{1'b1, 32'h18, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h18};

    // reset with every request asserted
    pre_we = 0; pre_addr = 0; pre_data = 0;
    reset = 1;
    bus.cpu_rd = 1; bus.cpu_wr = 1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h1;
    bus.dma_req = 1; bus.dma_wr = 1; bus.dma_addr = 32'h30; bus.dma_wdata = 32'h2; bus.dma_last = 0;
    #1;
    sample();
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    advance();
    preload(32'h20, 32'h1234_5678);
    preload(32'h24, 32'h2424_2424);
    preload(32'h40, 32'h0BAD_F00D);
    preload(32'hC4, 32'h5555_5555);
    reset = 0;
    idle_inputs();
    sample();
    chk("post_rst_stall_cnt", stall_cnt, 0);
    chk("post_rst_gnt", bus.dma_gnt, 0);
    advance();

    // idle CPU, 3-beat DMA write burst, then CPU reads back
    for (int i = 0; i < 6; i++) begin
      bus.cpu_rd = vt[i].cpu_rd; bus.cpu_addr = vt[i].cpu_addr;
      bus.dma_req = vt[i].dma_req; bus.dma_wr = 1; bus.dma_addr = vt[i].dma_addr;
      bus.dma_wdata = vt[i].dma_wdata; bus.dma_last = vt[i].dma_last;
      if (vt[i].cpu_rd && !vt[i].e_stall) cpu_q.push_back(vt[i].dma_addr == 0 ?
        (vt[i].cpu_addr == 32'h10 ? 32'hA000_0010 : 32'hA000_0018) : 32'h0);
      sample();
      chk($sformatf("tbl%0d_gnt", i), bus.dma_gnt, vt[i].e_gnt);
      chk($sformatf("tbl%0d_stall", i), bus.cpu_stall, vt[i].e_stall);
      chk($sformatf("tbl%0d_mem_rd", i), bus.mem_rd, vt[i].e_rd);
      chk($sformatf("tbl%0d_mem_wr", i), bus.mem_wr, vt[i].e_wr);
      chk($sformatf("tbl%0d_mem_addr", i), bus.mem_addr, vt[i].e_addr);
      advance();
    end
    idle_inputs();
    sample();
    chk("burst3_stall_cnt", stall_cnt, 0);
    scoreboard_drained("burst3");
    advance();

    // preemption of a continuously reading CPU
    s0 = stall_cnt;
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      bus.cpu_rd = 1; bus.cpu_addr = 32'h20;
      bus.dma_req = (beat < 2); bus.dma_wr = 1;
      bus.dma_addr = 32'h30 + 32'(4 * beat); bus.dma_wdata = 32'hC0DE_0000 + 32'(beat);
      bus.dma_last = (beat == 1);
      eg = (c == 5 || c == 6);
      if (!eg) cpu_q.push_back(32'h1234_5678);
      sample();
      chk($sformatf("pre%0d_gnt", c), bus.dma_gnt, eg);
      chk($sformatf("pre%0d_stall", c), bus.cpu_stall, eg);
      if (bus.dma_gnt) beat++;
      advance();
    end
    idle_inputs();
    sample();
    chk("pre_stall_delta", stall_cnt - s0, 16'd2);
    chk("pre_mem34", mem[8'h0D], 32'hC0DE_0001);
    scoreboard_drained("pre");
    advance();

    // endless burst gets cut at MAX_BURST, then re-arbitrates after a CPU cycle
    s0 = stall_cnt;
    beat = 0;
    ngnt = 0;
    for (int c = 0; c < 20; c++) begin
      bus.cpu_rd = 1; bus.cpu_addr = 32'h24;
      bus.dma_req = 1; bus.dma_wr = 1; bus.dma_last = 0;
      bus.dma_addr = 32'h80 + 32'(4 * beat); bus.dma_wdata = 32'hB000_0000 + 32'(beat);
      eg = (c >= 5 && c <= 12) || c >= 18;
      if (!eg) cpu_q.push_back(32'h2424_2424);
      sample();
      chk($sformatf("cut%0d_gnt", c), bus.dma_gnt, eg);
      if (c == 14) chk("cut_stall_delta", stall_cnt - s0, 16'd8);
      if (bus.dma_gnt) begin
        beat++;
        if (c <= 13) ngnt++;
      end
      advance();
    end
    idle_inputs();
    sample();
    chk("cut_grants", ngnt, 8);
    chk("cut_mem9c", mem[8'h27], 32'hB000_0007);
    scoreboard_drained("cut");
    advance();
    sample();
    advance();

    // replay: CPU write stalled behind a DMA read of the same word
    wcount40 = 0;
    bus.dma_req = 1; bus.dma_wr = 0; bus.dma_addr = 32'h40; bus.dma_last = 1;
    sample();
    chk("rep0_gnt", bus.dma_gnt, 0);
    advance();
    bus.cpu_wr = 1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'hDEAD_BEEF;
    sample();
    chk("rep1_gnt", bus.dma_gnt, 1);
    chk("rep1_stall", bus.cpu_stall, 1);
    chk("rep1_mem_wr", bus.mem_wr, 0);
    chk("rep1_dma_rdata", bus.dma_rdata, 32'h0BAD_F00D);
    advance();
    bus.dma_req = 0;
    sample();
    chk("rep2_stall", bus.cpu_stall, 0);
    chk("rep2_mem_wr", bus.mem_wr, 1);
    advance();
    idle_inputs();
    sample();
    chk("rep_write_count", wcount40, 1);
    chk("rep_mem40", mem[8'h10], 32'hDEAD_BEEF);
    advance();

    // dma_last coinciding with the burst limit: one return, then a new grant
    beat = 0;
    for (int c = 0; c < 11; c++) begin
      bus.dma_req = (beat < 9); bus.dma_wr = 1;
      bus.dma_addr = 32'h100 + 32'(4 * beat); bus.dma_wdata = 32'hF000_0000 + 32'(beat);
      bus.dma_last = (beat == 7 || beat == 8);
      eg = (c >= 1 && c <= 8) || c == 10;
      sample();
      chk($sformatf("lim%0d_gnt", c), bus.dma_gnt, eg);
      if (bus.dma_gnt) beat++;
      advance();
    end
    idle_inputs();
    sample();
    advance();

    // reset in the middle of a 5-beat burst
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      reset = (c == 2);
      if (c < 3) begin
        bus.dma_req = 1; bus.dma_wr = 1; bus.dma_last = 0;
        bus.dma_addr = 32'hC0 + 32'(4 * beat); bus.dma_wdata = 32'hE0 + 32'(beat);
      end else begin
        bus.dma_req = (c < 5); bus.dma_wr = 1; bus.dma_last = 1;
        bus.dma_addr = 32'hD0; bus.dma_wdata = 32'hE2;
      end
      eg = (c == 1 || c == 4);
      sample();
      chk($sformatf("rmb%0d_gnt", c), bus.dma_gnt, eg);
      chk($sformatf("rmb%0d_mem_wr", c), bus.mem_wr, eg);
      if (c == 3) chk("rmb_stall_cnt", stall_cnt, 0);
      if (bus.dma_gnt) beat++;
      advance();
    end
    idle_inputs();
    sample();
    chk("rmb_memC0", mem[8'h30], 32'hE0);
    chk("rmb_memC4", mem[8'h31], 32'h5555_5555);
    chk("rmb_memD0", mem[8'h34], 32'hE2);
    scoreboard_drained("end");
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
